// File: rtl/sdsu_bus_pkg.sv
// Shared constants and types for the SDSU multiplier bus master.
package sdsu_bus_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int OP_W_DEF    = 16;
   localparam int TIMEOUT_DEF = 255;

   // Slave register map: 0..2 are control/operand registers, never a product target.
   localparam logic [4:0]  CTRL_ADDR = 5'd0;
   localparam logic [4:0]  OPA_ADDR  = 5'd1;
   localparam logic [4:0]  OPB_ADDR  = 5'd2;
   localparam logic [31:0] GO_CMD    = 32'd1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR_A  = 3'd1,
      ST_WR_B  = 3'd2,
      ST_WR_GO = 3'd3,
      ST_ARM   = 3'd4,
      ST_WAIT  = 3'd5,
      ST_RESP  = 3'd6
   } master_state_t;

endpackage

// File: rtl/sdsu_bus_watchdog.sv
// WAIT-phase watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module sdsu_bus_watchdog
   import sdsu_bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   // expire_o marks the last permitted cycle, so the caller can still let ready win.
   assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && !expire_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule

// File: rtl/sdsu_bus_master.sv
// Bus master that sequences a multiply job on the SDSU slave and returns the product.
module sdsu_bus_master
   import sdsu_bus_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int OP_W    = OP_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_a,
   input  logic [OP_W-1:0]   req_b,
   input  logic [ADDR_W-1:0] req_dst,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_err,
   output logic              valid,
   output logic [ADDR_W-1:0] WAddr,
   output logic [DATA_W-1:0] WData,
   output logic [ADDR_W-1:0] RAddr,
   input  logic [DATA_W-1:0] RData,
   input  logic              ready
);

   master_state_t   state_q;
   logic [OP_W-1:0] b_q;
   logic            wd_expire_s;
   logic            in_wait_s;
   logic            dst_illegal_s;

   assign in_wait_s     = (state_q == ST_WAIT);
   assign dst_illegal_s = (req_dst <= ADDR_W'(OPB_ADDR));

   sdsu_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (!in_wait_s),
      .enable_i (in_wait_s),
      .expire_o (wd_expire_s)
   );

   // Bus outputs are loaded on the transition into each state so they are valid for that whole state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         b_q       <= '0;
         req_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
         valid     <= 1'b0;
         WAddr     <= '0;
         WData     <= '0;
         RAddr     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  b_q       <= req_b;
                  if (dst_illegal_s) begin
                     state_q   <= ST_RESP;
                     res_valid <= 1'b1;
                     res_err   <= 1'b1;
                     res_data  <= '0;
                  end else begin
                     state_q <= ST_WR_A;
                     valid   <= 1'b1;
                     WAddr   <= ADDR_W'(OPA_ADDR);
                     WData   <= {{(DATA_W-OP_W){1'b0}}, req_a};
                     RAddr   <= req_dst;
                  end
               end
            end
            ST_WR_A: begin
               state_q <= ST_WR_B;
               WAddr   <= ADDR_W'(OPB_ADDR);
               WData   <= {{(DATA_W-OP_W){1'b0}}, b_q};
            end
            ST_WR_B: begin
               state_q <= ST_WR_GO;
               WAddr   <= ADDR_W'(CTRL_ADDR);
               WData   <= DATA_W'(GO_CMD);
            end
            ST_WR_GO: begin
               // Start bit stays on WData with the strobe low for one cycle.
               state_q <= ST_ARM;
               valid   <= 1'b0;
               WAddr   <= ADDR_W'(CTRL_ADDR);
               WData   <= DATA_W'(GO_CMD);
            end
            ST_ARM: begin
               state_q <= ST_WAIT;
               WData   <= '0;
            end
            ST_WAIT: begin
               if (ready) begin
                  state_q   <= ST_RESP;
                  res_valid <= 1'b1;
                  res_data  <= RData;
                  res_err   <= 1'b0;
               end else if (wd_expire_s) begin
                  state_q   <= ST_RESP;
                  res_valid <= 1'b1;
                  res_data  <= '0;
                  res_err   <= 1'b1;
               end
            end
            ST_RESP: begin
               if (res_ready) begin
                  state_q   <= ST_IDLE;
                  res_valid <= 1'b0;
                  res_data  <= '0;
                  res_err   <= 1'b0;
                  RAddr     <= '0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               req_ready <= 1'b1;
               res_valid <= 1'b0;
               res_data  <= '0;
               res_err   <= 1'b0;
               valid     <= 1'b0;
               WAddr     <= '0;
               WData     <= '0;
               RAddr     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdsu_bus_master.sv
// Directed bench for sdsu_bus_master with a behavioural multiplier slave.
module tb_sdsu_bus_master;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [4:0]  req_dst;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   logic        valid;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic [4:0]  RAddr;
   logic [31:0] RData;
   logic        ready;

   int errors = 0;
   int checks = 0;

   logic [36:0] trace[$];
   logic [31:0] opa_m = 32'd0;
   logic [31:0] opb_m = 32'd0;

   sdsu_bus_master #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_dst   (req_dst),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .valid     (valid),
      .WAddr     (WAddr),
      .WData     (WData),
      .RAddr     (RAddr),
      .RData     (RData),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: records every bus write and multiplies the operands it was given.
   always @(posedge clk) begin
      if (valid) begin
         trace.push_back({WAddr, WData});
         if (WAddr == 5'd1) opa_m <= WData;
         if (WAddr == 5'd2) opb_m <= WData;
      end
   end
   assign RData = opa_m * opb_m;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 40'(req_ready), 40'd1);
      chk({tag, "_res_valid"}, 40'(res_valid), 40'd0);
      chk({tag, "_res_err"},   40'(res_err),   40'd0);
      chk({tag, "_res_data"},  40'(res_data),  40'd0);
      chk({tag, "_valid"},     40'(valid),     40'd0);
      chk({tag, "_WAddr"},     40'(WAddr),     40'd0);
      chk({tag, "_WData"},     40'(WData),     40'd0);
      chk({tag, "_RAddr"},     40'(RAddr),     40'd0);
   endtask

   // rdy_wait: WAIT cycle in which the slave raises ready (0 = never). Latency counted from accept.
   task automatic do_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] dst, input int rdy_wait, input logic hold_rr,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
      int k;
      int guard;
      trace.delete();
      res_ready = hold_rr;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_req_ready_idle"}, 40'(req_ready), 40'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_dst   = dst;
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      while (!res_valid && k < 400) begin
         if (k == 1) begin
            chk({tag, "_req_ready_low"}, 40'(req_ready), 40'd0);
            chk({tag, "_RAddr_wra"},     40'(RAddr),     40'(dst));
         end
         if (k == 4) begin
            chk({tag, "_arm_valid"}, 40'(valid), 40'd0);
            chk({tag, "_arm_WData"}, 40'(WData), 40'd1);
         end
         if (k == 5) begin
            chk({tag, "_wait_WData"}, 40'(WData), 40'd0);
            chk({tag, "_wait_RAddr"}, 40'(RAddr), 40'(dst));
         end
         // Stale ready during WR_GO must be ignored.
         ready = (k == 3) || (rdy_wait > 0 && k == 4 + rdy_wait);
         @(negedge clk);
         k++;
      end
      ready = 1'b0;
      chk({tag, "_latency"},   40'(k),         40'(exp_lat));
      chk({tag, "_res_data"},  40'(res_data),  40'(exp_data));
      chk({tag, "_res_err"},   40'(res_err),   40'(exp_err));
      chk({tag, "_req_ready"}, 40'(req_ready), 40'd0);
      if (dst > 5'd2) begin
         chk({tag, "_trace_len"}, 40'(trace.size()), 40'd3);
         if (trace.size() >= 3) begin
            chk({tag, "_trace0"}, 40'(trace[0]), 40'({5'd1, 16'd0, a}));
            chk({tag, "_trace1"}, 40'(trace[1]), 40'({5'd2, 16'd0, b}));
            chk({tag, "_trace2"}, 40'(trace[2]), 40'({5'd0, 32'd1}));
         end
      end else begin
         chk({tag, "_trace_len"}, 40'(trace.size()), 40'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = hold_rr;
      chk({tag, "_res_valid_drop"}, 40'(res_valid), 40'd0);
      chk({tag, "_req_ready_back"}, 40'(req_ready), 40'd1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = 16'd0;
      req_b     = 16'd0;
      req_dst   = 5'd0;
      res_ready = 1'b0;
      ready     = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      do_job("j3x5",   16'd3,      16'd5,      5'd7,  4, 1'b0, 32'd15,         1'b0, 9);
      do_job("jffff",  16'hFFFF,   16'hFFFF,   5'd31, 4, 1'b0, 32'hFFFE0001,   1'b0, 9);
      do_job("b2b_1",  16'd2,      16'd4,      5'd8,  1, 1'b1, 32'd8,          1'b0, 6);
      do_job("b2b_2",  16'd6,      16'd7,      5'd9,  2, 1'b1, 32'd42,         1'b0, 7);
      res_ready = 1'b0;
      do_job("tmo",    16'd1,      16'd1,      5'd10, 0, 1'b0, 32'd0,          1'b1, 21);
      do_job("dst1",   16'd5,      16'd5,      5'd1,  0, 1'b0, 32'd0,          1'b1, 1);

      // Job abandoned by reset while waiting on a silent slave.
      req_valid = 1'b1;
      req_a     = 16'd4;
      req_b     = 16'd4;
      req_dst   = 5'd5;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("midwait_valid", 40'(valid), 40'd0);
      chk("midwait_RAddr", 40'(RAddr), 40'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("midrst");
      @(negedge clk);
      chk("midrst_no_resp", 40'(res_valid), 40'd0);

      do_job("j9x9",   16'd9,      16'd9,      5'd6,  2, 1'b0, 32'd81,         1'b0, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
